// File: rtl/period_meter.sv
// period_meter
//   Measures the rise-to-rise period and the high time of a slow signal in
//   units of clock_in cycles. sig_in is asynchronous and passes through a
//   two-flop synchronizer before any decision is made on it.
//
// Ports
//   clock_in    system clock, all logic on its rising edge
//   reset       synchronous, active-high; clears every flop, FSM to ARM
//   sig_in      slow signal to measure (asynchronous)
//   period      last measured rise-to-rise period, in cycles
//   high_time   high cycles within that period
//   meas_valid  one-cycle pulse when period/high_time are updated
//   timeout     sticky: no rising edge within 2^CNT_W-1 cycles
//   meas_count  completed measurements, wraps modulo 2^MCNT_W
//   state_dbg   current FSM state: 0 = ARM, 1 = IDLE, 2 = MEAS
//
// Output protocol: meas_valid is a pure strobe with no ready. period and
// high_time change only in the cycle meas_valid is high and are held until
// the next strobe; a consumer that needs them must capture on meas_valid.
module period_meter #(
  parameter int CNT_W  = 16,
  parameter int MCNT_W = 8
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              sig_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              meas_valid,
  output logic              timeout,
  output logic [MCNT_W-1:0] meas_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             s1;
  logic             s2;
  logic             d;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             rise;

  // s2 is the only synchronized copy of sig_in; d is its one-cycle history.
  assign rise      = s2 & ~d;
  assign state_dbg = state;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      d          <= 1'b0;
      state      <= ARM;
      period_cnt <= '0;
      high_cnt   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      meas_count <= '0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      d          <= s2;
      meas_valid <= 1'b0;

      case (state)
        // A low level must be seen before a rise is trusted, so a signal
        // that is already high when we (re)start cannot fake an edge.
        ARM: begin
          if (!s2) begin
            state <= IDLE;
          end
        end

        // The first rise only opens a measurement window.
        IDLE: begin
          if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
            state      <= MEAS;
          end
        end

        MEAS: begin
          if (rise) begin
            // A rise coinciding with saturation is still a valid report.
            period     <= period_cnt;
            high_time  <= high_cnt;
            meas_valid <= 1'b1;
            meas_count <= meas_count + 1'b1;
            timeout    <= 1'b0;
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
          end else if (period_cnt == CNT_MAX) begin
            // Window overflowed: drop it and re-arm; results are kept.
            timeout <= 1'b1;
            state   <= ARM;
          end else begin
            period_cnt <= period_cnt + 1'b1;
            // high_cnt can never pass period_cnt, so it needs no saturation.
            if (s2) begin
              high_cnt <= high_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= ARM;
        end
      endcase
    end
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, divided timebase signal (e.g. the 0.05 s toggle output of the stopwatch divider chain) in units of the fast system clock. It is the receiving end of the divider: it recovers the cycle count between rising edges and the duty, so the divider output can be checked in-system and slow timing signals can be decoded. It sits in the system clock domain and accepts an asynchronous input.

## Interface
- CNT_W, default 16: width of the period/high-time counters and outputs.
- MCNT_W, default 8: width of the measurement counter.
- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  slow signal to measure; asynchronous to clock_in.
- period  output  CNT_W  last measured rise-to-rise period, in clock_in cycles.
- high_time  output  CNT_W  last measured high time within that period, in cycles.
- meas_valid  output  1  one-cycle pulse when period/high_time are updated.
- timeout  output  1  sticky flag: no rising edge seen within 2^CNT_W-1 cycles.
- meas_count  output  MCNT_W  number of completed measurements; wraps modulo 2^MCNT_W.

## Operation
- Input path: two-flop synchronizer s1→s2, then history flop d. rise = s2 & ~d. Only s2 is used by the measurement logic.
- States: ARM, IDLE, MEAS.
- ARM: entered on reset and after timeout. Waits until s2 == 0 is sampled, then goes to IDLE. This prevents a false edge when sig_in is already high.
- IDLE: waits for rise. On rise: period_cnt <= 1, high_cnt <= 1, go to MEAS. No output update.
- MEAS, rise present: period <= period_cnt, high_time <= high_cnt, meas_valid <= 1, meas_count <= meas_count+1, timeout <= 0, then period_cnt <= 1 and high_cnt <= 1. Stay in MEAS.
- MEAS, no rise, period_cnt < 2^CNT_W-1: period_cnt +1. high_cnt +1 if s2 == 1, else it holds.
- MEAS, no rise, period_cnt == 2^CNT_W-1: timeout <= 1, go to ARM. period, high_time and meas_count hold. meas_valid stays 0.
- Rise and saturation in the same cycle: the rise wins. The measurement is reported with period = 2^CNT_W-1, and timeout is not set.
- high_cnt never exceeds period_cnt, so no separate saturation is needed.
- Result: a signal high for H cycles out of every P cycles (P ≥ 2, stable) gives period = P and high_time = H.
- meas_valid is 0 in every cycle that has no report.
- Reset while in any state: all flops clear and the FSM returns to ARM. A partial measurement is discarded.

## Timing
- Reset values: period=0, high_time=0, meas_valid=0, timeout=0, meas_count=0. s1=s2=d=0; state=ARM; period_cnt=0, high_cnt=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: sig_in rising before edge k gives s1=1 after k and s2=1 after k+1. The rise is acted on at edge k+2, so meas_valid is high during the cycle after edge k+2.
- The first report needs two rising edges after the arm condition. After reset with sig_in low: the first rise starts counting, the second rise produces the first meas_valid.
- The minimum measurable period is 2 cycles; narrower pulses may be lost in the synchronizer.
- Reports are at most one per P cycles; there is no backpressure. The consumer samples period/high_time on meas_valid, and they are held until the next report.

## Test plan
- Reset, then sig_in = 1 held -> FSM stays in ARM; meas_valid never pulses; all outputs remain 0.
- sig_in driven by a divide-by-10 toggle (5 cycles high, 5 low) for 4 periods -> 3 meas_valid pulses, 10 cycles apart; period=10, high_time=5; meas_count=3.
- Pulse train with P=7, H=2, then P=4, H=3 -> reports 7/2, then 4/3. The first report after the change is 4/3 once two rises at the new spacing have occurred.
- CNT_W=4, sig_in stuck low after one rise -> timeout=1 fifteen cycles after the count starts; no meas_valid. Resume a P=6 pattern -> first report 6/3 clears timeout, and meas_count increments.
- MCNT_W=2, 5 measurements -> meas_count sequence 1,2,3,0,1.
- Assert reset for 1 cycle mid-period while in MEAS -> all outputs 0 next cycle. The next report needs a fresh low level and then two rises; no stale partial count appears.
